// File: rtl/detect_pkg.sv
// Shared types and width helpers for the detection collector and its neighbours.
// Default-parameter window position and detection word layouts.
package detect_pkg;

  function automatic int calc_ws(input int scale_num);
    int w;
    w = $clog2(scale_num);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_IMG_WIDTH  = 45;
  localparam int DEF_IMG_HEIGHT = 45;
  localparam int DEF_SCALE_NUM  = 2;
  localparam int DEF_W_X        = $clog2(DEF_IMG_WIDTH);
  localparam int DEF_W_Y        = $clog2(DEF_IMG_HEIGHT);
  localparam int DEF_W_S        = calc_ws(DEF_SCALE_NUM);

  typedef struct packed {
    logic               eot;
    logic [DEF_W_S-1:0] scale;
    logic [DEF_W_Y-1:0] y;
    logic [DEF_W_X-1:0] x;
  } win_pos_t;

  typedef logic [DEF_W_S+DEF_W_Y+DEF_W_X-1:0] detect_pos_t;

endpackage

// File: rtl/detect_collector_if.sv
// Position, result and detection streams of the detection collector.
// detect_count exists only when DETECT_CAP_EN is defined.
interface detect_collector_if #(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int SCALE_NUM  = 2,
  parameter int MAX_DETECT = 64
);
  import detect_pkg::*;

  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);
  localparam int W_S = calc_ws(SCALE_NUM);
  localparam int W_C = $clog2(MAX_DETECT + 1);

  logic                   window_pos_valid;
  logic                   window_pos_ready;
  logic [W_X-1:0]         window_pos_x;
  logic [W_Y-1:0]         window_pos_y;
  logic [W_S-1:0]         window_pos_scale;
  logic                   window_pos_eot;
  logic                   result_valid;
  logic                   result_ready;
  logic                   result;
  logic                   detect_pos_valid;
  logic                   detect_pos_ready;
  logic [W_S+W_Y+W_X-1:0] detect_pos;
  logic                   detect_eot;
`ifdef DETECT_CAP_EN
  logic [W_C-1:0]         detect_count;
`endif

  modport slave (
    input  window_pos_valid, window_pos_x, window_pos_y, window_pos_scale, window_pos_eot,
    output window_pos_ready,
    input  result_valid, result,
    output result_ready,
    output detect_pos_valid, detect_pos, detect_eot,
`ifdef DETECT_CAP_EN
    output detect_count,
`endif
    input  detect_pos_ready
  );

  modport master (
    output window_pos_valid, window_pos_x, window_pos_y, window_pos_scale, window_pos_eot,
    input  window_pos_ready,
    output result_valid, result,
    input  result_ready,
    input  detect_pos_valid, detect_pos, detect_eot,
`ifdef DETECT_CAP_EN
    input  detect_count,
`endif
    output detect_pos_ready
  );

endinterface

// File: rtl/detect_collector_pos_fifo.sv
// Generic synchronous FIFO with registered full/empty; write visible to pop one cycle later.
// push_rdy = !full and pop_vld = !empty, with no bypass in either direction.
module pos_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push_vld,
  output logic push_rdy,
  input  T     push_dat,
  output logic pop_vld,
  input  logic pop_rdy,
  output T     pop_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign push_rdy = !full_q;
  assign pop_vld  = !empty_q;
  assign do_push  = push_vld & !full_q;
  assign do_pop   = pop_rdy & !empty_q;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // Flags only move when occupancy changes; push+pop together leaves them as is.
      case ({do_push, do_pop})
        2'b10: begin
          empty_q <= 1'b0;
          full_q  <= ((wr_ptr + PTR_ONE) == rd_ptr);
        end
        2'b01: begin
          full_q  <= 1'b0;
          empty_q <= ((rd_ptr + PTR_ONE) == wr_ptr);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/detect_collector.sv
// Pairs in-order classifier results with queued window positions; detection valid one cycle after result accept.
// Stalls results while the output register is held; DETECT_CAP_EN adds a per-frame detection cap and counter.
module detect_collector
  import detect_pkg::*;
#(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int SCALE_NUM  = 2,
  parameter int POS_DEPTH  = 8,
  parameter int MAX_DETECT = 64
) (
  input logic               clk,
  input logic               rst,
  detect_collector_if.slave io
);

  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);
  localparam int W_S = calc_ws(SCALE_NUM);

  typedef struct packed {
    logic           eot;
    logic [W_S-1:0] scale;
    logic [W_Y-1:0] y;
    logic [W_X-1:0] x;
  } pos_t;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  out_state_t             state_q, state_d;
  pos_t                   push_dat, head;
  logic                   head_vld, fifo_push_rdy;
  logic                   out_free, pop, emit, load, capped;
  logic [W_S+W_Y+W_X-1:0] out_pos_q;
  logic                   out_eot_q;

  assign push_dat = '{eot: io.window_pos_eot, scale: io.window_pos_scale,
                      y: io.window_pos_y, x: io.window_pos_x};

  pos_fifo #(.T(pos_t), .DEPTH(POS_DEPTH)) u_pos_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (io.window_pos_valid & !rst),
    .push_rdy (fifo_push_rdy),
    .push_dat (push_dat),
    .pop_vld  (head_vld),
    .pop_rdy  (pop),
    .pop_dat  (head)
  );

  assign io.window_pos_ready = fifo_push_rdy & !rst;
  assign out_free            = (state_q == OUT_EMPTY) | io.detect_pos_ready;
  assign pop                 = io.result_valid & head_vld & out_free & !rst;
  assign io.result_ready     = pop;
  // End-of-frame beats always go out, even for a negative or capped result.
  assign emit                = (io.result & !capped) | head.eot;
  assign load                = pop & emit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL:  if (io.detect_pos_ready && !load) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pos_q <= '0;
      out_eot_q <= 1'b0;
    end else if (load) begin
      out_pos_q <= {head.scale, head.y, head.x};
      out_eot_q <= head.eot;
    end
  end

  assign io.detect_pos_valid = (state_q == OUT_FULL);
  assign io.detect_pos       = out_pos_q;
  assign io.detect_eot       = out_eot_q;

`ifdef DETECT_CAP_EN
  localparam int W_C = $clog2(MAX_DETECT + 1);

  logic [W_C-1:0] cnt_q;
  logic           clr, inc;

  // The count restarts as the eot beat leaves, so a new frame may count in that same cycle.
  assign clr    = (state_q == OUT_FULL) & io.detect_pos_ready & out_eot_q;
  assign capped = (cnt_q == W_C'(MAX_DETECT)) & !clr;
  assign inc    = pop & io.result & !capped;

  always_ff @(posedge clk) begin
    if (rst)      cnt_q <= '0;
    else if (clr) cnt_q <= inc ? W_C'(1) : '0;
    else if (inc) cnt_q <= cnt_q + W_C'(1);
  end

  assign io.detect_count = cnt_q;
`else
  assign capped = 1'b0;
`endif

endmodule

// File: doc/detect_collector.md
# detect_collector

Pairs each classified window with its position and emits detections tagged with scale index and frame boundary, for a multi-scale cascade pipeline. Sits between the data fetcher's window-position stream and the classifier's result stream, and drives the detection output of the top level. Successor to the single-scale window-position matcher, adding:
- a parametrised-depth position queue,
- a scale field,
- end-of-frame signalling,
- an optional per-frame detection cap and counter.

## Interface
- IMG_WIDTH, 45: image width in pixels; W_X = $clog2(IMG_WIDTH).
- IMG_HEIGHT, 45: image height in pixels; W_Y = $clog2(IMG_HEIGHT).
- SCALE_NUM, 2: number of pyramid scales; W_S = max(1, $clog2(SCALE_NUM)).
- POS_DEPTH, 8: position queue depth, power of two, ≥ 2.
- MAX_DETECT, 64: per-frame detection cap (used only with DETECT_CAP_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- window_pos_valid  in  1  position valid.
- window_pos_ready  out  1  position accepted.
- window_pos_x  in  W_X  window left column.
- window_pos_y  in  W_Y  window top row.
- window_pos_scale  in  W_S  scale index.
- window_pos_eot  in  1  last window of frame.
- result_valid  in  1  classifier result valid.
- result_ready  out  1  result accepted.
- result  in  1  1 = window passed all stages.
- detect_pos_valid  out  1  detection valid.
- detect_pos_ready  in  1  detection accepted.
- detect_pos  out  W_S+W_Y+W_X  {scale, y, x}.
- detect_eot  out  1  frame-done marker, qualified by detect_pos_valid.
- detect_count  out  $clog2(MAX_DETECT+1)  detections emitted in the current frame; present only with DETECT_CAP_EN.

## Operation
- Position queue: FIFO of {eot, scale, y, x}, POS_DEPTH entries.
  - window_pos_ready = !full.
  - Push on window_pos_valid & window_pos_ready.
- Results arrive in the same order as positions. No result ever precedes its position.
- Pop condition: result_valid & !empty & out_free, where out_free = !out_valid | detect_pos_ready.
  - result_ready equals this pop condition; pop and result accept happen in the same cycle.
- Output register state machine, two states:
  - EMPTY → FULL when a pop with emit=1 occurs.
  - FULL → EMPTY on detect_pos_ready with no new emit.
  - FULL stays FULL on ready with a simultaneous emit.
- emit = (result=1 & !capped) | head.eot.
  - If result=1: detect_pos = head position, detect_eot = head.eot.
  - If result=0 and head.eot=1: emit a frame-done beat; detect_pos = head position, detect_eot = 1.
  - If result=0 and head.eot=0: pop and drop silently.
- Queue full and empty never bypass.
  - A push into a full queue is not accepted, even with a simultaneous pop.
  - A result arriving with an empty queue is not accepted, even with a simultaneous push; it is accepted the next cycle.
- detect_pos and detect_eot hold stable while detect_pos_valid & !detect_pos_ready.

## Timing
- Result accepted at cycle N → detect_pos_valid high at N+1.
- Position push to earliest pop: 1 cycle, because the queue registers its write.
- Throughput: one result per cycle while the output drains every cycle.
- Reset values: window_pos_ready=0 during rst, 1 the cycle after. result_ready=0, detect_pos_valid=0, detect_pos=0, detect_eot=0, detect_count=0, queue empty.
- Reset mid-operation flushes the queue and the output register. Partial-frame state is discarded.

## Configuration
- DETECT_CAP_EN defined: a counter increments on each emitted result=1 beat.
  - capped = (count == MAX_DETECT). Further positive results are popped and dropped.
  - The eot beat is always emitted.
  - The counter clears on the cycle the eot beat is accepted downstream.
  - detect_count port exists.
- Without DETECT_CAP_EN: capped = 0, no counter, no detect_count port.

## Structure
- Shared package detect_pkg holds:
  - W_S computation function.
  - typedef struct packed {logic eot; scale; y; x} win_pos_t.
  - typedef of detect_pos.
- One sub-module: pos_fifo.
  - Synchronous FIFO parametrised by type/width and depth.
  - Registered full/empty flags.
  - Reused elsewhere in the pipeline.

## Test plan
- Push positions (3,4,s0), (5,6,s1,eot), then results 1, 0. Expected: one beat {0,4,3} with eot=0, then one beat {1,6,5} with eot=1.
- Fill POS_DEPTH=8 positions with no results. Expected: window_pos_ready=0 on the 9th. A simultaneous push+pop at full accepts only the pop.
- Assert result_valid with an empty queue and a same-cycle push. Expected: result_ready=0 that cycle, 1 the next; detect_pos_valid one cycle later.
- Hold detect_pos_ready=0 for 5 cycles with a pending detection. Expected: output stable, result_ready=0. Release ready and the next result is accepted that same cycle.
- DETECT_CAP_EN with MAX_DETECT=2: 4 positive results, last with eot. Expected: 2 detection beats plus the eot beat; detect_count=2, then 0 after eot is accepted.
- Assert rst with 3 queued positions and a full output register. Expected: all outputs at reset values next cycle, queue empty, no stale detection afterwards.
